// File: rtl/esaxi_pkg.sv
// Shared encodings, widths and helpers for the eMesh AXI slave read bridge.
package esaxi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned LEN_W  = 8;
  localparam int unsigned BEAT_W = LEN_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} rd_state_t;

  // WRAP is treated as INCR; FIXED and the reserved encoding hold the address.
  function automatic logic burst_advances(input logic [1:0] burst);
    return (burst == BURST_INCR) || (burst == BURST_WRAP);
  endfunction

endpackage

// File: rtl/esaxi_rd_fifo.sv
// First-word fall-through return-data FIFO with occupancy count.
module esaxi_rd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wr_en_i,
  input  logic [DW-1:0]          wr_data_i,
  input  logic                   rd_en_i,
  output logic [DW-1:0]          rd_data_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full, push, pop;

  always_comb begin
    full    = (count_q == CW'(DEPTH));
    empty_o = (count_q == '0);
    push    = wr_en_i && !full;
    pop     = rd_en_i && !empty_o;
    wptr_d  = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d  = pop ? rptr_q + PW'(1) : rptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    rd_data_o = empty_o ? '0 : mem_q[rptr_q];
    count_o   = count_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= wr_data_i;
  end

  // Upstream credit accounting must never let a write land on a full FIFO.
  assert property (@(posedge clk_i) disable iff (rst_i) !(wr_en_i && full));

endmodule

// File: rtl/esaxi_slave_read.sv
// AXI4 read slave: splits one AR burst into eMesh read requests and replays returns on R.
module esaxi_slave_read
  import esaxi_pkg::*;
#(
  parameter int unsigned RFIFO_DEPTH = 4,
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32,
  parameter int unsigned IDW         = 12
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [AW-1:0]  s_axi_araddr,
  input  logic [7:0]     s_axi_arlen,
  input  logic [2:0]     s_axi_arsize,
  input  logic [1:0]     s_axi_arburst,
  input  logic [IDW-1:0] s_axi_arid,
  input  logic           s_axi_arvalid,
  output logic           s_axi_arready,
  output logic [DW-1:0]  s_axi_rdata,
  output logic [IDW-1:0] s_axi_rid,
  output logic [1:0]     s_axi_rresp,
  output logic           s_axi_rlast,
  output logic           s_axi_rvalid,
  input  logic           s_axi_rready,
  output logic           rd_req_valid,
  output logic [AW-1:0]  rd_req_addr,
  output logic [1:0]     rd_req_size,
  input  logic           rd_req_ready,
  input  logic           rd_rsp_valid,
  input  logic [DW-1:0]  rd_rsp_data
);

  localparam int unsigned CW  = $clog2(RFIFO_DEPTH) + 1;
  localparam int unsigned CRW = CW + 1;

  rd_state_t         state_q, state_d;
  logic              arready_q, arready_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [2:0]        size_q, size_d;
  logic [1:0]        burst_q, burst_d;
  logic [IDW-1:0]    id_q, id_d;
  logic [BEAT_W-1:0] req_left_q, req_left_d;
  logic [BEAT_W-1:0] rsp_left_q, rsp_left_d;
  logic [CW-1:0]     inflight_q, inflight_d;

  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  logic [DW-1:0]     fifo_rdata;
  logic [CRW-1:0]    credit;
  logic              req_hs, rsp_push, r_hs;

  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a, input logic [2:0] sz);
    logic [AW-1:0] step;
    step = AW'(1) << sz;
    return (a & ~(step - AW'(1))) + step;
  endfunction

  esaxi_rd_fifo #(
    .DEPTH (RFIFO_DEPTH),
    .DW    (DW)
  ) u_rd_fifo (
    .clk_i     (clk),
    .rst_i     (rst),
    .wr_en_i   (rsp_push),
    .wr_data_i (rd_rsp_data),
    .rd_en_i   (r_hs),
    .rd_data_o (fifo_rdata),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  always_comb begin
    // Slots not yet spoken for by buffered data or reads still in flight.
    credit        = CRW'(RFIFO_DEPTH) - {1'b0, fifo_count} - {1'b0, inflight_q};
    rd_req_valid  = (state_q == ISSUE) && (req_left_q != '0) && (credit != '0);
    req_hs        = rd_req_valid && rd_req_ready;
    rsp_push      = rd_rsp_valid && (inflight_q != '0);
    s_axi_rvalid  = !fifo_empty;
    r_hs          = s_axi_rvalid && s_axi_rready;
    s_axi_rlast   = s_axi_rvalid && (rsp_left_q == BEAT_W'(1));
    s_axi_rdata   = fifo_rdata;
    s_axi_rid     = id_q;
    s_axi_rresp   = RESP_OKAY;
    s_axi_arready = arready_q;
    rd_req_addr   = addr_q;
    rd_req_size   = size_q[1:0];
  end

  always_comb begin
    state_d    = state_q;
    arready_d  = arready_q;
    addr_d     = addr_q;
    size_d     = size_q;
    burst_d    = burst_q;
    id_d       = id_q;
    req_left_d = req_left_q;
    rsp_left_d = r_hs ? rsp_left_q - BEAT_W'(1) : rsp_left_q;

    case ({req_hs, rsp_push})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase

    unique case (state_q)
      IDLE: begin
        if (s_axi_arvalid && arready_q) begin
          addr_d     = s_axi_araddr;
          size_d     = s_axi_arsize;
          burst_d    = s_axi_arburst;
          id_d       = s_axi_arid;
          req_left_d = {1'b0, s_axi_arlen} + BEAT_W'(1);
          rsp_left_d = {1'b0, s_axi_arlen} + BEAT_W'(1);
          arready_d  = 1'b0;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (req_hs) begin
          req_left_d = req_left_q - BEAT_W'(1);
          if (burst_advances(burst_q)) addr_d = next_addr(addr_q, size_q);
          if (req_left_q == BEAT_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (r_hs && s_axi_rlast) begin
          state_d   = IDLE;
          arready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      arready_q  <= 1'b1;
      addr_q     <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      id_q       <= '0;
      req_left_q <= '0;
      rsp_left_q <= '0;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      arready_q  <= arready_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      burst_q    <= burst_d;
      id_q       <= id_d;
      req_left_q <= req_left_d;
      rsp_left_q <= rsp_left_d;
      inflight_q <= inflight_d;
    end
  end

endmodule

// File: tb/tb_esaxi_slave_read.sv
// Scoreboard bench for esaxi_slave_read: randomized eMesh/R behaviour against a burst-level model.
module tb_esaxi_slave_read;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned IDW   = 12;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [AW-1:0]  s_axi_araddr = '0;
  logic [7:0]     s_axi_arlen = '0;
  logic [2:0]     s_axi_arsize = '0;
  logic [1:0]     s_axi_arburst = '0;
  logic [IDW-1:0] s_axi_arid = '0;
  logic           s_axi_arvalid = 1'b0;
  logic           s_axi_arready;
  logic [DW-1:0]  s_axi_rdata;
  logic [IDW-1:0] s_axi_rid;
  logic [1:0]     s_axi_rresp;
  logic           s_axi_rlast;
  logic           s_axi_rvalid;
  logic           s_axi_rready = 1'b0;
  logic           rd_req_valid;
  logic [AW-1:0]  rd_req_addr;
  logic [1:0]     rd_req_size;
  logic           rd_req_ready = 1'b0;
  logic           rd_rsp_valid = 1'b0;
  logic [DW-1:0]  rd_rsp_data = '0;

  always #5 clk = ~clk;

  esaxi_slave_read #(
    .RFIFO_DEPTH (DEPTH),
    .AW          (AW),
    .DW          (DW),
    .IDW         (IDW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arlen   (s_axi_arlen),
    .s_axi_arsize  (s_axi_arsize),
    .s_axi_arburst (s_axi_arburst),
    .s_axi_arid    (s_axi_arid),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rid     (s_axi_rid),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rlast   (s_axi_rlast),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .rd_req_valid  (rd_req_valid),
    .rd_req_addr   (rd_req_addr),
    .rd_req_size   (rd_req_size),
    .rd_req_ready  (rd_req_ready),
    .rd_rsp_valid  (rd_rsp_valid),
    .rd_rsp_data   (rd_rsp_data)
  );

  typedef struct {
    logic [DW-1:0]  data;
    logic [IDW-1:0] id;
    logic           last;
  } rbeat_t;

  typedef struct {
    logic [IDW-1:0] id;
    logic           last;
  } meta_t;

  logic [AW-1:0] exp_addr_q[$];
  logic [1:0]    exp_size_q[$];
  meta_t         meta_q[$];
  rbeat_t        exp_r_q[$];

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int pending = 0, ghost = 0, outstanding = 0, req_cnt = 0, pop_cnt = 0;
  int req_ready_pct = 100, rsp_gap_pct = 0, rready_mode = 1, rsp_budget = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Beat k address straight from the burst rules: aligned start plus k beats, wrapping mod 2^AW.
  function automatic logic [AW-1:0] model_addr(input logic [AW-1:0] start, input int size,
                                               input logic [1:0] burst, input int k);
    longint unsigned bytes, base;
    if (burst == 2'b00 || burst == 2'b11 || k == 0) return start;
    bytes = longint'(1) << size;
    base  = (longint'(start) / bytes) * bytes;
    return AW'(base + longint'(k) * bytes);
  endfunction

  // eMesh request monitor
  initial forever begin
    @(negedge clk);
    if (rst) continue;
    if (rd_req_valid && rd_req_ready) begin
      chk("req_expected", exp_addr_q.size() != 0, 1);
      if (exp_addr_q.size() != 0) begin
        chk("req_addr", rd_req_addr, exp_addr_q.pop_front());
        chk("req_size", rd_req_size, exp_size_q.pop_front());
      end
      pending++;
      req_cnt++;
      outstanding++;
      chk("outstanding_le_depth", outstanding <= DEPTH, 1);
    end
  end

  // R channel monitor
  logic           hold_v = 1'b0;
  logic [DW-1:0]  hold_d;
  logic [IDW-1:0] hold_id;
  logic           hold_l;
  bit             arready_chk = 1'b0;

  initial forever begin
    rbeat_t b;
    @(negedge clk);
    if (rst) begin
      hold_v      = 1'b0;
      arready_chk = 1'b0;
      continue;
    end
    if (arready_chk) begin
      chk("arready_after_last", s_axi_arready, 1);
      arready_chk = 1'b0;
    end
    if (hold_v) begin
      chk("hold_rvalid", s_axi_rvalid, 1);
      chk("hold_rdata", s_axi_rdata, hold_d);
      chk("hold_rid", s_axi_rid, hold_id);
      chk("hold_rlast", s_axi_rlast, hold_l);
    end
    hold_v  = s_axi_rvalid && !s_axi_rready;
    hold_d  = s_axi_rdata;
    hold_id = s_axi_rid;
    hold_l  = s_axi_rlast;
    if (s_axi_rvalid && s_axi_rready) begin
      chk("r_beat_expected", exp_r_q.size() != 0, 1);
      if (exp_r_q.size() != 0) begin
        b = exp_r_q.pop_front();
        chk("rdata", s_axi_rdata, b.data);
        chk("rid", s_axi_rid, b.id);
        chk("rlast", s_axi_rlast, b.last);
        chk("rresp", s_axi_rresp, 2'b00);
        if (b.last) begin
          chk("arready_during_last", s_axi_arready, 0);
          arready_chk = 1'b1;
        end
      end
      pop_cnt++;
      outstanding--;
    end
  end

  // eMesh responder and ready drivers
  initial forever begin
    meta_t m;
    @(posedge clk);
    #2;
    rd_req_ready = ($urandom_range(99) < req_ready_pct);
    case (rready_mode)
      0:       s_axi_rready = 1'($urandom_range(1));
      1:       s_axi_rready = 1'b1;
      2:       s_axi_rready = 1'b0;
      default: s_axi_rready = !s_axi_rready;
    endcase
    rd_rsp_valid = 1'b0;
    if (ghost > 0) begin
      rd_rsp_valid = 1'b1;
      rd_rsp_data  = $urandom;
      ghost--;
    end else if (pending > 0 && rsp_budget != 0 && meta_q.size() != 0 &&
                 $urandom_range(99) >= rsp_gap_pct) begin
      m            = meta_q.pop_front();
      rd_rsp_valid = 1'b1;
      rd_rsp_data  = $urandom;
      exp_r_q.push_back('{rd_rsp_data, m.id, m.last});
      pending--;
      if (rsp_budget > 0) rsp_budget--;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_arready"}, s_axi_arready, 1);
    chk({tag, "_rvalid"}, s_axi_rvalid, 0);
    chk({tag, "_rlast"}, s_axi_rlast, 0);
    chk({tag, "_rresp"}, s_axi_rresp, 0);
    chk({tag, "_rid"}, s_axi_rid, 0);
    chk({tag, "_rdata"}, s_axi_rdata, 0);
    chk({tag, "_req_valid"}, rd_req_valid, 0);
    chk({tag, "_req_addr"}, rd_req_addr, 0);
    chk({tag, "_req_size"}, rd_req_size, 0);
  endtask

  task automatic do_ar(input logic [AW-1:0] addr, input int len, input int size,
                       input logic [1:0] burst, input logic [IDW-1:0] id);
    bit acc = 1'b0;
    s_axi_araddr  = addr;
    s_axi_arlen   = 8'(len);
    s_axi_arsize  = 3'(size);
    s_axi_arburst = burst;
    s_axi_arid    = id;
    s_axi_arvalid = 1'b1;
    for (int t = 0; t < 300 && !acc; t++) begin
      @(negedge clk);
      acc = s_axi_arready;
    end
    chk("ar_accepted", acc, 1);
    if (acc) begin
      for (int k = 0; k <= len; k++) begin
        exp_addr_q.push_back(model_addr(addr, size, burst, k));
        exp_size_q.push_back(2'(size));
        meta_q.push_back('{id, k == len});
      end
    end
    tick();
    s_axi_arvalid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit done = 1'b0;
    for (int t = 0; t < budget && !done; t++) begin
      @(negedge clk);
      done = (exp_r_q.size() == 0) && (exp_addr_q.size() == 0) && (pending == 0) &&
             (meta_q.size() == 0) && s_axi_arready;
    end
    chk("burst_complete", done, 1);
    tick();
  endtask

  task automatic set_modes(input int rdy_pct, input int gap_pct, input int rmode);
    req_ready_pct = rdy_pct;
    rsp_gap_pct   = gap_pct;
    rready_mode   = rmode;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base, p0, len;
    bit ok;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle("reset");
    tick();

    // Aligned INCR with immediate returns
    set_modes(100, 0, 1);
    do_ar(32'h0000_1000, 3, 2, 2'b01, 12'h5A3);
    wait_done(200);

    // FIXED halfword burst at an unaligned address
    do_ar(32'h0000_2002, 2, 1, 2'b00, 12'h123);
    wait_done(200);

    // Credit stall with R held off
    set_modes(100, 0, 2);
    base = req_cnt;
    do_ar(32'h0000_3000, 7, 2, 2'b01, 12'h077);
    repeat (20) @(negedge clk);
    chk("stall_req_count", req_cnt - base, DEPTH);
    chk("stall_req_valid", rd_req_valid, 0);
    tick();
    rready_mode = 1;
    wait_done(300);

    // R backpressure toggling every cycle, irregular eMesh timing
    set_modes(70, 30, 3);
    do_ar(32'h0000_4000, 9, 2, 2'b01, 12'hBEE);
    wait_done(500);

    // INCR crossing the top of the address space
    set_modes(100, 0, 1);
    do_ar(32'hFFFF_FFFC, 1, 2, 2'b01, 12'h0F1);
    wait_done(200);

    // Reset mid-burst with returns still owed by eMesh
    rsp_budget = 3;
    p0 = pop_cnt;
    do_ar(32'h0000_5000, 4, 2, 2'b01, 12'h009);
    ok = 1'b0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      ok = (pop_cnt - p0) >= 2;
    end
    chk("rst_setup_two_beats", ok, 1);
    rready_mode = 2;
    tick();
    rst = 1'b1;
    ghost += pending;
    pending = 0;
    exp_addr_q.delete();
    exp_size_q.delete();
    meta_q.delete();
    exp_r_q.delete();
    outstanding = 0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_idle("midrst");
    rready_mode = 1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      chk("late_rsp_dropped", s_axi_rvalid, 0);
    end
    tick();
    rsp_budget = -1;
    do_ar(32'h0000_6000, 0, 2, 2'b01, 12'hABC);
    wait_done(200);

    // Randomized bursts, including one maximum-length burst
    for (int i = 0; i < 40; i++) begin
      set_modes(int'($urandom_range(100, 40)), int'($urandom_range(50)), 0);
      len = (i == 20) ? 255 : int'($urandom_range(15));
      do_ar($urandom, len, int'($urandom_range(2)), 2'($urandom_range(3)), 12'($urandom));
      wait_done(60 * (len + 1) + 200);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
